fifo_read_ctrl: RTL

Read-side controller for a dual-clock FIFO with power-of-two depth. It holds an (ADDR_W+1)-bit binary/Gray read pointer and drives the storage read address. It synchronises the write-domain Gray pointer through a parametrised flop chain and generates registered empty, almost-empty, fill-level and sticky underflow-error status. It sits in the read clock domain, between the FIFO storage array and the write-side controller, which consumes rptr_gray.

---
 rtl/fifo_read_ctrl_if.sv | 25 ++
 rtl/fifo_read_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/fifo_read_ctrl_if.sv
// Read-side port bundle of the dual-clock FIFO controller.
// The slave modport is the controller; the master modport is the reading client.
interface fifo_read_ctrl_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic              rinc;
    logic [ADDR_W:0]   wptr_gray;
    logic              rclr_err;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   rptr_gray;
    logic              rempty;
    logic              ralmost_empty;
    logic [ADDR_W:0]   rlevel;
    logic              rerr_underflow;

    modport master (
        output rinc, wptr_gray, rclr_err,
        input  raddr, rptr_gray, rempty, ralmost_empty, rlevel, rerr_underflow
    );

    modport slave (
        input  rinc, wptr_gray, rclr_err,
        output raddr, rptr_gray, rempty, ralmost_empty, rlevel, rerr_underflow
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of a dual-clock FIFO: binary/Gray read pointer, write-pointer
// synchroniser, and registered empty / almost-empty / level / sticky underflow status.
module fifo_read_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 2
) (
    input logic             clk,
    input logic             rst,
    fifo_read_ctrl_if.slave bus
);
    localparam int unsigned PtrW  = ADDR_W + 1;
    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AeThresh = PtrW'(AE_THRESH);

    if (ADDR_W < 2) begin : gen_bad_addr_w
        $error("fifo_read_ctrl: ADDR_W must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
        $error("fifo_read_ctrl: SYNC_STAGES must be >= 2");
    end
    if (AE_THRESH > Depth) begin : gen_bad_ae_thresh
        $error("fifo_read_ctrl: AE_THRESH must not exceed DEPTH");
    end

    logic [ADDR_W:0] rbin_q, rbin_d;
    logic [ADDR_W:0] rgray_q, rgray_d;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] wq_gray, wq_bin;
    logic [ADDR_W:0] lvl_d, rlevel_q;
    logic            rempty_q, rae_q, rerr_q, rerr_d;
    logic            rd_fire;

    // Plain flop chain, nothing between stages, so each bit resolves independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_bin = '0;
        for (int i = 0; i < PtrW; i++) begin
            wq_bin[i] = ^(wq_gray >> i);
        end
    end

    always_comb begin
        rd_fire = bus.rinc & ~rempty_q;
        rbin_d  = rbin_q + {{ADDR_W{1'b0}}, rd_fire};
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        // Modular subtraction stays correct across pointer wrap.
        lvl_d   = wq_bin - rbin_d;
        // A new underflow in the same cycle as a clear keeps the flag set.
        rerr_d  = (bus.rinc & rempty_q) | (rerr_q & ~bus.rclr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
            rlevel_q <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= (rgray_d == wq_gray);
            rae_q    <= (lvl_d <= AeThresh);
            rlevel_q <= lvl_d;
            rerr_q   <= rerr_d;
        end
    end

    assign bus.raddr          = rbin_q[ADDR_W-1:0];
    assign bus.rptr_gray      = rgray_q;
    assign bus.rempty         = rempty_q;
    assign bus.ralmost_empty  = rae_q;
    assign bus.rlevel         = rlevel_q;
    assign bus.rerr_underflow = rerr_q;
endmodule
